// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the icache/dcache memory-port arbiter.
package mem_arbiter_pkg;

    localparam int DEF_LINE_BITS  = 64;
    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_CNT_W      = 3;

    // Arbiter states. The grant states double as the owner of the
    // transaction in flight, so no separate owner register is kept.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DWR  = 3'd1,
        ST_DRD  = 3'd2,
        ST_IRD  = 3'd3,
        ST_RESP = 3'd4
    } arb_state_t;

    // Line fills always start on a line boundary.
    function automatic logic [31:0] line_addr(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of dcache grants made while the icache is waiting.
module mem_arb_starve_cnt
#(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
)(
    input  logic clk,
    input  logic rst,
    input  logic dc_grant,
    input  logic ic_grant,
    input  logic ic_waiting,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    // Clear on an icache grant, count dcache grants that bypass a waiting icache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ic_grant) begin
            cnt <= '0;
        end else if (dc_grant && ic_waiting && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between icache line fills and dcache
// line fills / masked write-through words. One transaction at a time.
//
// state | meaning
// IDLE  | no transaction; pick next requester from the sampled levels
// DWR   | dcache masked word write outstanding on the memory port
// DRD   | dcache line read outstanding
// IRD   | icache line read outstanding
// RESP  | one-cycle reply pulse to the owner; requests are not sampled here
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BITS  = DEF_LINE_BITS,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int CNT_W      = DEF_CNT_W
)(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ic_req_i,
    input  logic [31:0]          ic_addr_i,
    output logic                 ic_rep_o,
    output logic [LINE_BITS-1:0] ic_rep_data_o,

    input  logic                 dc_req_i,
    input  logic                 dc_write_i,
    input  logic [31:0]          dc_addr_i,
    input  logic [31:0]          dc_wdata_i,
    input  logic [3:0]           dc_wmask_i,
    output logic                 dc_rep_o,
    output logic [LINE_BITS-1:0] dc_rep_data_o,
    output logic                 dc_wack_o,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_wmask_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_rdata_i
);

    arb_state_t state;
    arb_state_t sel;
    logic       starve;
    logic       dc_grant;
    logic       ic_grant;

    // Grant selection, only meaningful in IDLE; ST_IDLE means no grant.
    always_comb begin
        sel = ST_IDLE;
        if (state == ST_IDLE) begin
            if (starve && ic_req_i) begin
                sel = ST_IRD;
            end else if (dc_write_i) begin
                sel = ST_DWR;
            end else if (dc_req_i) begin
                sel = ST_DRD;
            end else if (ic_req_i) begin
                sel = ST_IRD;
            end
        end
    end

    assign dc_grant = (sel == ST_DWR) || (sel == ST_DRD);
    assign ic_grant = (sel == ST_IRD);

    mem_arb_starve_cnt #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .dc_grant   (dc_grant),
        .ic_grant   (ic_grant),
        .ic_waiting (ic_req_i),
        .at_max     (starve)
    );

    // Arbitration FSM with registered memory-side and reply-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_wmask_o   <= '0;
            ic_rep_o      <= 1'b0;
            dc_rep_o      <= 1'b0;
            dc_wack_o     <= 1'b0;
            ic_rep_data_o <= '0;
            dc_rep_data_o <= '0;
        end else begin
            ic_rep_o  <= 1'b0;
            dc_rep_o  <= 1'b0;
            dc_wack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (sel)
                        ST_DWR: begin
                            state       <= ST_DWR;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= dc_addr_i;
                            mem_wdata_o <= dc_wdata_i;
                            mem_wmask_o <= dc_wmask_i;
                        end
                        ST_DRD: begin
                            state       <= ST_DRD;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= line_addr(dc_addr_i);
                            mem_wdata_o <= '0;
                            mem_wmask_o <= '0;
                        end
                        ST_IRD: begin
                            state       <= ST_IRD;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= line_addr(ic_addr_i);
                            mem_wdata_o <= '0;
                            mem_wmask_o <= '0;
                        end
                        default: ;
                    endcase
                end
                ST_DWR: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        dc_wack_o <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_DRD: begin
                    if (mem_ack_i) begin
                        mem_req_o     <= 1'b0;
                        dc_rep_o      <= 1'b1;
                        dc_rep_data_o <= mem_rdata_i;
                        state         <= ST_RESP;
                    end
                end
                ST_IRD: begin
                    if (mem_ack_i) begin
                        mem_req_o     <= 1'b0;
                        ic_rep_o      <= 1'b1;
                        ic_rep_data_o <= mem_rdata_i;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory
// transactions and replies; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ic_req_i = 1'b0;
    logic [31:0] ic_addr_i = '0;
    logic        ic_rep_o;
    logic [63:0] ic_rep_data_o;
    logic        dc_req_i = 1'b0;
    logic        dc_write_i = 1'b0;
    logic [31:0] dc_addr_i = '0;
    logic [31:0] dc_wdata_i = '0;
    logic [3:0]  dc_wmask_i = '0;
    logic        dc_rep_o;
    logic [63:0] dc_rep_data_o;
    logic        dc_wack_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_ack_i = 1'b0;
    logic [63:0] mem_rdata_i = '0;

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_i      (ic_req_i),
        .ic_addr_i     (ic_addr_i),
        .ic_rep_o      (ic_rep_o),
        .ic_rep_data_o (ic_rep_data_o),
        .dc_req_i      (dc_req_i),
        .dc_write_i    (dc_write_i),
        .dc_addr_i     (dc_addr_i),
        .dc_wdata_i    (dc_wdata_i),
        .dc_wmask_i    (dc_wmask_i),
        .dc_rep_o      (dc_rep_o),
        .dc_rep_data_o (dc_rep_data_o),
        .dc_wack_o     (dc_wack_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_exp_t;

    typedef struct {
        int          kind;   // 0 icache read, 1 dcache read, 2 dcache write ack
        logic [63:0] data;
    } rsp_exp_t;

    mem_exp_t    exp_mem[$];
    rsp_exp_t    exp_rsp[$];
    logic [63:0] rdata_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int ack_cyc    = -10;
    int mem_delay  = 1;
    int stray_req  = 0;
    int stray_done = 0;
    int ic_left    = 0;
    int dc_left    = 0;
    int wr_left    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [63:0] line_of(input logic [31:0] a);
        return {a, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: got 0x%0h, required nothing (t=%0t)", name, act, $time);
    endtask

    task automatic exp_m(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        exp_mem.push_back(e);
    endtask

    task automatic exp_r(input int kind, input logic [63:0] data);
        rsp_exp_t r;
        r.kind = kind; r.data = data;
        exp_rsp.push_back(r);
    endtask

    // Memory model: ack after mem_delay cycles of a held request.
    int mcnt  = 0;
    bit acked = 1'b0;
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (stray_req != stray_done) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
            stray_done++;
        end else if (!mem_req_o) begin
            mcnt  = 0;
            acked = 1'b0;
        end else if (!acked) begin
            if (mcnt >= mem_delay) begin
                mem_ack_i = 1'b1;
                acked     = 1'b1;
                ack_cyc   = cyc;
                if (mem_we_o)
                    mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
                else if (rdata_q.size() > 0)
                    mem_rdata_i = rdata_q.pop_front();
                else
                    mem_rdata_i = line_of(mem_addr_o);
            end else begin
                mcnt++;
            end
        end
    end

    // Monitor: memory-side transactions and reply pulses.
    bit          prev_req = 1'b0;
    logic [68:0] cap = '0;
    always @(negedge clk) begin
        mem_exp_t e;
        rsp_exp_t r;
        int       npulse;
        int       kind;
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req_o && !prev_req) begin
                if (exp_mem.size() == 0) begin
                    bad("mem_unexpected_req", 64'(mem_addr_o));
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_we", 64'(mem_we_o), 64'(e.we));
                    chk("mem_addr", 64'(mem_addr_o), 64'(e.addr));
                    if (e.we) begin
                        chk("mem_wdata", 64'(mem_wdata_o), 64'(e.wdata));
                        chk("mem_wmask", 64'(mem_wmask_o), 64'(e.wmask));
                    end
                end
                cap = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o};
            end else if (mem_req_o) begin
                chk("mem_stable", 64'({mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}), 64'(cap));
            end
            prev_req = mem_req_o;

            npulse = int'(ic_rep_o) + int'(dc_rep_o) + int'(dc_wack_o);
            if (npulse > 1) begin
                bad("multi_pulse", 64'({ic_rep_o, dc_rep_o, dc_wack_o}));
            end else if (npulse == 1) begin
                kind = ic_rep_o ? 0 : (dc_rep_o ? 1 : 2);
                if (exp_rsp.size() == 0) begin
                    bad("rsp_unexpected", 64'(kind));
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_kind", 64'(kind), 64'(r.kind));
                    if (kind == 0) chk("ic_rep_data", ic_rep_data_o, r.data);
                    if (kind == 1) chk("dc_rep_data", dc_rep_data_o, r.data);
                    chk("rsp_latency", 64'(cyc), 64'(ack_cyc + 1));
                end
            end
        end
    end

    // Requester model: raise outstanding requests, drop each on its reply.
    task automatic service(input int budget);
        int n = 0;
        while ((ic_left + dc_left + wr_left) > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (ic_rep_o) begin
                ic_req_i = 1'b0; ic_left--;
            end else if (!ic_req_i && ic_left > 0) begin
                ic_req_i = 1'b1;
            end
            if (dc_rep_o) begin
                dc_req_i = 1'b0; dc_left--;
            end else if (!dc_req_i && dc_left > 0) begin
                dc_req_i = 1'b1;
            end
            if (dc_wack_o) begin
                dc_write_i = 1'b0; wr_left--;
            end else if (!dc_write_i && wr_left > 0) begin
                dc_write_i = 1'b1;
            end
        end
        if ((ic_left + dc_left + wr_left) > 0) begin
            bad("service_timeout", 64'(ic_left + dc_left + wr_left));
            ic_left = 0; dc_left = 0; wr_left = 0;
            ic_req_i = 1'b0; dc_req_i = 1'b0; dc_write_i = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_pulses", 64'({ic_rep_o, dc_rep_o, dc_wack_o}), 64'd0);
        chk("rst_ic_data", ic_rep_data_o, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single icache read, ack 2 cycles after mem_req_o
        mem_delay = 2;
        rdata_q.push_back(64'h1122_3344_5566_7788);
        exp_m(1'b0, 32'h0000_1230, 32'h0, 4'h0);
        exp_r(0, 64'h1122_3344_5566_7788);
        ic_addr_i = 32'h0000_1234;
        ic_req_i  = 1'b1;
        ic_left   = 1;
        @(negedge clk);
        chk("ic_req_latency", 64'(mem_req_o), 64'd1);
        service(50);

        // Stray ack in IDLE
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_mem_req", 64'(mem_req_o), 64'd0);
        chk("stray_ic_data", ic_rep_data_o, 64'h1122_3344_5566_7788);
        chk("stray_dc_data", dc_rep_data_o, 64'd0);

        // Masked write
        mem_delay  = 1;
        dc_addr_i  = 32'h0000_0104;
        dc_wdata_i = 32'hDEAD_BEEF;
        dc_wmask_i = 4'b0011;
        exp_m(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011);
        exp_r(2, 64'h0);
        wr_left = 1;
        service(50);
        chk("wr_keeps_dc_data", dc_rep_data_o, 64'd0);

        // Simultaneous write, dcache read, icache read; zero-delay memory
        mem_delay  = 0;
        ic_addr_i  = 32'h2000_004D;
        dc_addr_i  = 32'h0000_0FFC;
        dc_wdata_i = 32'h1234_5678;
        dc_wmask_i = 4'b1111;
        exp_m(1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'b1111);
        exp_m(1'b0, 32'h0000_0FF8, 32'h0, 4'h0);
        exp_m(1'b0, 32'h2000_0048, 32'h0, 4'h0);
        exp_r(2, 64'h0);
        exp_r(1, line_of(32'h0000_0FF8));
        exp_r(0, line_of(32'h2000_0048));
        ic_left = 1; dc_left = 1; wr_left = 1;
        service(100);

        // Starvation: icache forced after 4 dcache grants, twice
        mem_delay = 1;
        dc_addr_i = 32'h0000_0040;
        ic_addr_i = 32'h0000_0080;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 4; k++) begin
                exp_m(1'b0, 32'h0000_0040, 32'h0, 4'h0);
                exp_r(1, line_of(32'h0000_0040));
            end
            exp_m(1'b0, 32'h0000_0080, 32'h0, 4'h0);
            exp_r(0, line_of(32'h0000_0080));
        end
        dc_left = 8; ic_left = 2;
        service(400);

        // Reset mid-DRD: request abandoned, re-granted after release
        mem_delay = 30;
        dc_addr_i = 32'h0000_0333;
        exp_m(1'b0, 32'h0000_0330, 32'h0, 4'h0);
        exp_m(1'b0, 32'h0000_0330, 32'h0, 4'h0);
        exp_r(1, line_of(32'h0000_0330));
        dc_req_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_mem_req", 64'(mem_req_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("async_rst_dc_rep", 64'(dc_rep_o), 64'd0);
        @(negedge clk);
        mem_delay = 1;
        rst       = 1'b1;
        dc_left   = 1;
        service(50);

        chk("exp_mem_drained", 64'(exp_mem.size()), 64'd0);
        chk("exp_rsp_drained", 64'(exp_rsp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
